key_conditioner: RTL

- Parametrised, multi-channel input conditioner for the game's player push-buttons.
- It is the next generation of the two-flop input buffer. Each channel gets a configurable-depth synchroniser, a stability-count debouncer, and one-cycle press/release pulses.
- Sits between the raw KEY/switch pins and the game FSMs (flap, start, player inputs). One instance serves all players.

---
 rtl/key_conditioner.sv | 67 ++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Multi-channel push-button conditioner: per-channel synchroniser, stability-count
// debouncer and registered one-cycle press/release pulses.
module key_conditioner #(
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_rise
);

  localparam int unsigned   CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;

  always_comb begin
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], in[c]};
      // Any return to the accepted level restarts qualification from zero.
      if (sync_q[c][SYNC_STAGES-1] == level_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CntLast) begin
        level_d[c] = sync_q[c][SYNC_STAGES-1];
        cnt_d[c]   = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + CntW'(1);
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign any_rise = |rise_q;

endmodule
